// File: rtl/sme_add_arbiter_if.sv
// Bus bundle for sme_add_arbiter: two requesters, the randomness source and the shared
// masked adder. The arbiter takes the slave view, the surrounding system the master view.
interface sme_add_arbiter_if #(
    parameter int D = 3,
    parameter int N = 32,
    parameter int G = D + D * (D - 1) / 2
);
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_sub;
    logic [N*D-1:0]   req0_mxor;
    logic [N*D-1:0]   req0_mand;
    logic             rsp0_valid;
    logic             rsp0_ready;

    logic             req1_valid;
    logic             req1_ready;
    logic             req1_sub;
    logic [N*D-1:0]   req1_mxor;
    logic [N*D-1:0]   req1_mand;
    logic             rsp1_valid;
    logic             rsp1_ready;

    logic [N*D-1:0]   rsp_rd;

    logic             rng_valid;
    logic [N*G-1:0]   rng_data;
    logic             rng_take;

    logic             add_en;
    logic             add_sub;
    logic [N*D-1:0]   add_mxor;
    logic [N*D-1:0]   add_mand;
    logic [N*G-1:0]   add_rng;
    logic [N*D-1:0]   add_rd;
    logic             add_rdy;

    modport slave (
        input  req0_valid, req0_sub, req0_mxor, req0_mand, rsp0_ready,
        input  req1_valid, req1_sub, req1_mxor, req1_mand, rsp1_ready,
        input  rng_valid, rng_data, add_rd, add_rdy,
        output req0_ready, rsp0_valid, req1_ready, rsp1_valid, rsp_rd,
        output rng_take, add_en, add_sub, add_mxor, add_mand, add_rng
    );

    modport master (
        output req0_valid, req0_sub, req0_mxor, req0_mand, rsp0_ready,
        output req1_valid, req1_sub, req1_mxor, req1_mand, rsp1_ready,
        output rng_valid, rng_data, add_rd, add_rdy,
        input  req0_ready, rsp0_valid, req1_ready, rsp1_valid, rsp_rd,
        input  rng_take, add_en, add_sub, add_mxor, add_mand, add_rng
    );
endinterface

// File: rtl/sme_add_arbiter.sv
// Round-robin arbiter sharing one masked add/sub unit between two requesters.
// Optional SME_ARB_ZEROISE_EN clears operand/rng/result registers after each response handoff.
module sme_add_arbiter #(
    parameter int D = 3,
    parameter int N = 32,
    parameter int G = D + D * (D - 1) / 2
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    sme_add_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_owner;
    logic             r_last;
    logic             r_sub;
    logic [N*D-1:0]   r_mxor;
    logic [N*D-1:0]   r_mand;
    logic [N*G-1:0]   r_rng;
    logic [N*D-1:0]   r_res;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_rsp_ready;
    logic             w_handoff;
    logic             w_sel_sub;
    logic [N*D-1:0]   w_sel_mxor;
    logic [N*D-1:0]   w_sel_mand;

    assign w_accept    = w_grant0 | w_grant1;
    assign w_rsp_ready = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
    assign w_handoff   = (r_state == RESP) && w_rsp_ready;
    assign w_sel_sub   = w_grant1 ? bus.req1_sub : bus.req0_sub;

    for (genvar gi = 0; gi < D; gi++) begin : g_share_sel
        assign w_sel_mxor[gi*N +: N] = w_grant1 ? bus.req1_mxor[gi*N +: N] : bus.req0_mxor[gi*N +: N];
        assign w_sel_mand[gi*N +: N] = w_grant1 ? bus.req1_mand[gi*N +: N] : bus.req0_mand[gi*N +: N];
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_last names the requester served most recently; on a tie the other one wins.
    always_comb begin
        w_state_next = r_state;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.rng_valid) begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        w_grant0 = r_last;
                        w_grant1 = !r_last;
                    end else begin
                        w_grant0 = bus.req0_valid;
                        w_grant1 = bus.req1_valid;
                    end
                end
                if (w_grant0 || w_grant1) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (bus.add_rdy) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (w_rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.rng_take   = w_accept;
    assign bus.add_en     = (r_state == RUN);
    assign bus.add_sub    = r_sub;
    assign bus.add_mxor   = r_mxor;
    assign bus.add_mand   = r_mand;
    assign bus.add_rng    = r_rng;
    assign bus.rsp0_valid = (r_state == RESP) && !r_owner;
    assign bus.rsp1_valid = (r_state == RESP) && r_owner;
    assign bus.rsp_rd     = r_res;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_sub   <= 1'b0;
            r_mxor  <= '0;
            r_mand  <= '0;
            r_rng   <= '0;
            r_res   <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant1;
                r_sub   <= w_sel_sub;
                r_mxor  <= w_sel_mxor;
                r_mand  <= w_sel_mand;
                r_rng   <= bus.rng_data;
            end
            // A done pulse outside RUN belongs to nobody and is dropped.
            if ((r_state == RUN) && bus.add_rdy) begin
                r_res  <= bus.add_rd;
                r_last <= r_owner;
            end
`ifdef SME_ARB_ZEROISE_EN
            if (w_handoff) begin
                r_sub  <= 1'b0;
                r_mxor <= '0;
                r_mand <= '0;
                r_rng  <= '0;
                r_res  <= '0;
            end
`else
            if (w_handoff) begin
                r_sub <= r_sub;
            end
`endif
        end
    end
endmodule

// File: tb/tb_sme_add_arbiter.sv
// Randomized self-checking bench for sme_add_arbiter with a transaction-level reference model
// and a behavioural 6-cycle masked adder.
module tb_sme_add_arbiter;
    localparam int D = 3;
    localparam int N = 32;
    localparam int G = D + D * (D - 1) / 2;
    localparam int S = N * D;
    localparam int W = N * G;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sme_add_arbiter_if #(.D(D), .N(N), .G(G)) bus();
    sme_add_arbiter #(.D(D), .N(N), .G(G)) dut (.g_clk(clk), .g_resetn(rstn), .bus(bus));

    function automatic logic [N-1:0] recomb(input logic [S-1:0] s);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < D; i++) r = r ^ s[i*N +: N];
        return r;
    endfunction

    function automatic logic [S-1:0] split(input logic [N-1:0] v);
        logic [S-1:0] s;
        logic [N-1:0] acc;
        acc = v;
        for (int i = 0; i < D - 1; i++) begin
            s[i*N +: N] = $urandom;
            acc = acc ^ s[i*N +: N];
        end
        s[(D-1)*N +: N] = acc;
        return s;
    endfunction

    // Behavioural adder: done in the 6th enabled cycle, fresh output masks per operation.
    int unsigned  add_cnt;
    logic [N-1:0] mask0 = '0;
    logic [N-1:0] mask1 = '0;
    logic [N-1:0] add_sum;
    logic         spur = 1'b0;
    always @(posedge clk or negedge rstn) begin
        if (!rstn)            add_cnt <= 0;
        else if (!bus.add_en) add_cnt <= 0;
        else                  add_cnt <= add_cnt + 1;
    end
    always @(posedge clk) begin
        if (!bus.add_en) begin
            mask0 <= $urandom;
            mask1 <= $urandom;
        end
    end
    assign add_sum     = bus.add_sub ? recomb(bus.add_mxor) - recomb(bus.add_mand)
                                     : recomb(bus.add_mxor) + recomb(bus.add_mand);
    assign bus.add_rd  = {add_sum ^ mask0 ^ mask1, mask1, mask0};
    assign bus.add_rdy = (bus.add_en && add_cnt == 5) || (!bus.add_en && spur);

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: owner (-1 = none), accept cycle, expected arithmetic result.
    int           cyc = 0;
    int           m_owner = -1;
    int           m_last = 1;
    int           m_t = 0;
    int           m_hand = 0;
    logic [N-1:0] m_a, m_b, m_exp;
    logic         m_sub;
    logic [W-1:0] m_rng;
    logic [S-1:0] m_held;
    int           hist[$];

    task automatic step();
        int w;
        int k;
        @(negedge clk);
        cyc++;
        if (m_owner < 0) begin
            w = -1;
            if (bus.rng_valid) begin
                if (bus.req0_valid && bus.req1_valid) w = 1 - m_last;
                else if (bus.req0_valid)              w = 0;
                else if (bus.req1_valid)              w = 1;
            end
            chk("req0_ready", W'(bus.req0_ready), W'(w == 0));
            chk("req1_ready", W'(bus.req1_ready), W'(w == 1));
            chk("rng_take",   W'(bus.rng_take),   W'(w >= 0));
            chk("idle_add_en", W'(bus.add_en), '0);
            chk("idle_rsp_valid", W'({bus.rsp1_valid, bus.rsp0_valid}), '0);
`ifdef SME_ARB_ZEROISE_EN
            chk("idle_rsp_rd_zero", W'(bus.rsp_rd), '0);
`endif
            if (w >= 0) begin
                m_owner = w;
                m_t     = cyc;
                m_a     = recomb(w == 0 ? bus.req0_mxor : bus.req1_mxor);
                m_b     = recomb(w == 0 ? bus.req0_mand : bus.req1_mand);
                m_sub   = (w == 0) ? bus.req0_sub : bus.req1_sub;
                m_rng   = bus.rng_data;
                m_exp   = m_sub ? m_a - m_b : m_a + m_b;
                hist.push_back(w);
            end
        end else begin
            k = cyc - m_t;
            chk("busy_ready", W'({bus.req1_ready, bus.req0_ready, bus.rng_take}), '0);
            chk("add_en", W'(bus.add_en), W'(k <= 6));
            chk("rsp0_valid", W'(bus.rsp0_valid), W'(k >= 7 && m_owner == 0));
            chk("rsp1_valid", W'(bus.rsp1_valid), W'(k >= 7 && m_owner == 1));
            if (k <= 6) begin
                chk("add_opa", W'(recomb(bus.add_mxor)), W'(m_a));
                chk("add_opb", W'(recomb(bus.add_mand)), W'(m_b));
                chk("add_sub", W'(bus.add_sub), W'(m_sub));
                chk("add_rng", bus.add_rng, m_rng);
            end else begin
                chk("rsp_value", W'(recomb(bus.rsp_rd)), W'(m_exp));
                if (k == 7) m_held = bus.rsp_rd;
                else chk("rsp_stable", W'(bus.rsp_rd), W'(m_held));
                if ((m_owner == 0 && bus.rsp0_ready) || (m_owner == 1 && bus.rsp1_ready)) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_hand  = cyc;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int who, input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
        if (who == 0) begin
            bus.req0_valid = 1'b1; bus.req0_sub = sub; bus.req0_mxor = split(a); bus.req0_mand = split(b);
        end else begin
            bus.req1_valid = 1'b1; bus.req1_sub = sub; bus.req1_mxor = split(a); bus.req1_mand = split(b);
        end
    endtask

    task automatic wait_accept(input string tag, input int who);
        int n0;
        int i;
        n0 = hist.size();
        i  = 0;
        while (hist.size() == n0 && i < 50) begin
            step();
            i++;
        end
        chk({tag, "_winner"}, W'(hist.size() > n0 ? hist[hist.size()-1] : 9), W'(who));
        if (who == 0) bus.req0_valid = 1'b0;
        else          bus.req1_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int who, input logic [N-1:0] exp, input int hold);
        int i;
        i = 0;
        while (!(m_owner >= 0 && cyc - m_t >= 6) && i < 50) begin
            step();
            i++;
        end
        chk({tag, "_valid"}, W'(who == 0 ? bus.rsp0_valid : bus.rsp1_valid), W'(1));
        chk({tag, "_result"}, W'(recomb(bus.rsp_rd)), W'(exp));
        for (int j = 0; j < hold; j++) step();
        if (who == 0) bus.rsp0_ready = 1'b1;
        else          bus.rsp1_ready = 1'b1;
        step();
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
    endtask

    initial begin
        bus.req0_valid = 0; bus.req0_sub = 0; bus.req0_mxor = '0; bus.req0_mand = '0; bus.rsp0_ready = 0;
        bus.req1_valid = 0; bus.req1_sub = 0; bus.req1_mxor = '0; bus.req1_mand = '0; bus.rsp1_ready = 0;
        bus.rng_valid = 0; bus.rng_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", W'({bus.req0_ready, bus.req1_ready, bus.rng_take, bus.add_en,
                                 bus.rsp0_valid, bus.rsp1_valid}), '0);
        chk("reset_rsp_rd", W'(bus.rsp_rd), '0);
        chk("reset_add_mxor", W'(bus.add_mxor), '0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Starvation by rng, then contention alternating 0,1,0.
        for (int i = 0; i < G; i++) bus.rng_data[i*N +: N] = $urandom;
        drive_req(0, 32'h10, 32'h20, 1'b0);
        drive_req(1, 32'h100, 32'h1, 1'b1);
        repeat (10) step();
        bus.rng_valid = 1'b1;
        wait_accept("starve", 0);
        drive_req(0, 32'h7, 32'h9, 1'b0);
        wait_resp("starve_rsp", 0, 32'h30, 0);
        wait_accept("cont1", 1);
        drive_req(1, 32'h100, 32'h1, 1'b1);
        wait_resp("cont1_rsp", 1, 32'hFF, 0);
        wait_accept("cont2", 0);
        bus.req1_valid = 1'b0;
        wait_resp("cont2_rsp", 0, 32'h10, 0);

        // Single add and subtract wrap.
        drive_req(0, 32'h5, 32'h3, 1'b0);
        wait_accept("add", 0);
        wait_resp("add_rsp", 0, 32'h8, 0);
        drive_req(1, 32'h0, 32'h1, 1'b1);
        wait_accept("subwrap", 1);
        wait_resp("subwrap_rsp", 1, 32'hFFFF_FFFF, 0);

        // Backpressure: req1 must wait until the held response is taken, then win next cycle.
        drive_req(0, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0);
        wait_accept("bp", 0);
        drive_req(1, 32'h5, 32'h6, 1'b1);
        wait_resp("bp_rsp", 0, 32'hDEAD_BEEF, 20);
        wait_accept("bp_next", 1);
        chk("bp_turnaround", W'(m_t), W'(m_hand + 1));
        wait_resp("bp_next_rsp", 1, 32'hFFFF_FFFF, 0);

        // Reset in the third enabled cycle discards the operation.
        drive_req(0, 32'h1234, 32'h1111, 1'b0);
        wait_accept("rst", 0);
        step();
        step();
        rstn = 1'b0;
        #1;
        chk("rst_add_en", W'(bus.add_en), '0);
        chk("rst_rsp_valid", W'({bus.rsp1_valid, bus.rsp0_valid}), '0);
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        m_owner = -1;
        m_last  = 1;
        drive_req(0, 32'h1234, 32'h1111, 1'b0);
        wait_accept("post_rst", 0);
        wait_resp("post_rst_rsp", 0, 32'h2345, 0);

        // Randomized traffic, including stray done pulses.
        for (int c = 0; c < 3000; c++) begin
            bus.req0_valid = 1'($urandom % 2);
            bus.req0_sub   = 1'($urandom);
            bus.req0_mxor  = split($urandom);
            bus.req0_mand  = split($urandom);
            bus.req1_valid = 1'($urandom % 2);
            bus.req1_sub   = 1'($urandom);
            bus.req1_mxor  = split($urandom);
            bus.req1_mand  = split($urandom);
            bus.rng_valid  = ($urandom % 10) < 7;
            for (int i = 0; i < G; i++) bus.rng_data[i*N +: N] = $urandom;
            bus.rsp0_ready = 1'($urandom % 2);
            bus.rsp1_ready = 1'($urandom % 2);
            spur           = ($urandom % 10) == 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sme_add_arbiter.md
Name: sme_add_arbiter

Overview:
- Shares one masked Kogge-Stone add/sub unit between two requesters (requester 0, requester 1).
- Arbitrates round-robin and latches the winner's masked operands plus one fresh randomness word.
- Drives the adder enable until the adder's done pulse, then buffers the masked result until the owning requester accepts it.
- Sits between the masked ALU / address-generation front ends and the single shared adder instance.

Parameters:
D, 3, number of shares.
N, 32, operand width per share.
G, D+D*(D-1)/2, number of randomness (guard) shares the adder consumes.

Ports:
g_clk  in  1  global clock.
g_resetn  in  1  reset; one clock, asynchronous, active-low.
req0_valid  in  1  requester 0 operation request.
req0_ready  out  1  requester 0 operands accepted this cycle.
req0_sub  in  1  requester 0: 1=subtract, 0=add.
req0_mxor  in  N*D  requester 0 operand A shares.
req0_mand  in  N*D  requester 0 operand B shares.
rsp0_valid  out  1  result held for requester 0.
rsp0_ready  in  1  requester 0 takes the result.
req1_valid, req1_ready, req1_sub, req1_mxor, req1_mand, rsp1_valid, rsp1_ready  -  same as requester 0, for requester 1.
rsp_rd  out  N*D  result shares, valid while either rsp*_valid is high.
rng_valid  in  1  fresh randomness available.
rng_data  in  N*G  randomness word.
rng_take  out  1  one-cycle pulse: randomness consumed.
add_en  out  1  adder enable.
add_sub  out  1  adder subtract select.
add_mxor  out  N*D  adder operand A shares.
add_mand  out  N*D  adder operand B shares.
add_rng  out  N*G  adder randomness.
add_rd  in  N*D  adder result shares.
add_rdy  in  1  adder done; one cycle, result valid in the same cycle.

Behaviour:
- State machine: IDLE, RUN, RESP. Reset state is IDLE.
- Reset values: all outputs 0, operand/rng/result registers 0, owner=0, last-served pointer=1 (so requester 0 wins the first tie).
- IDLE:
  - A grant requires some reqX_valid=1 and rng_valid=1.
  - If only one requester is valid, it wins.
  - If both are valid, the one not last served wins.
  - In the accept cycle: reqX_ready=1 (combinational, at most one), rng_take=1.
  - Latch sub/mxor/mand/rng_data and the owner; go to RUN.
  - If rng_valid=0, no ready is asserted and the FSM stays in IDLE.
- RUN:
  - add_en=1; add_sub/add_mxor/add_mand/add_rng are driven from the latched registers, stable for the whole operation.
  - On add_rdy=1: capture add_rd into the result register, update the last-served pointer to the owner, go to RESP.
  - add_en falls the cycle after add_rdy.
  - With the standard adder, add_rdy arrives in the 6th add_en cycle.
- RESP:
  - rspX_valid=1 for the owner only; rsp_rd is driven from the result register.
  - On rspX_ready=1, go to IDLE. The next grant is possible at the earliest on the following cycle (no same-cycle turnaround).
- Latency: accept at cycle T, add_en high T+1..T+6, rsp valid from T+7.
- add_rdy seen outside RUN is ignored.
- rsp*_ready while the matching rsp*_valid is low is ignored.
- A requester dropping reqX_valid before it is accepted is legal; a request with no ack carries no obligation.
- req*_ready, rng_take and rsp*_valid are never high in the same cycle.
- Asynchronous reset mid-RUN or mid-RESP: immediate return to IDLE with add_en=0 and rsp*_valid=0; the in-flight result is discarded. The adder's own sequencer reset is the integrator's responsibility.
- Output arithmetic is unmodified: rsp_rd equals add_rd shares, with XOR of shares = A±B mod 2^N.

Optional Feature:
- Macro SME_ARB_ZEROISE_EN.
- Defined:
  - The cycle after a response handoff, the result register, the latched operand registers and the latched rng register are cleared to 0.
  - This clear prevents stale shares from lingering.
  - rsp_rd reads 0 while idle.
  - Grant timing is unchanged: the clear overlaps the first IDLE cycle.
- Undefined: the registers hold their last values until overwritten by the next accept.

Test Plan:
- Single add: req0 with A=0x00000005, B=0x00000003 (shares random, XOR-recombined), sub=0, rng_valid=1 -> req0_ready and rng_take at T; add_en T+1..T+6; rsp0_valid at T+7 with recombined rsp_rd=0x00000008.
- Subtract wrap: req1 with A=0x00000000, B=0x00000001, sub=1 -> recombined result 0xFFFFFFFF on rsp1; rsp0_valid stays 0.
- Contention: req0 and req1 valid together from reset -> req0 served first, then req1; with both still requesting, the next grant alternates back to req0.
- Starvation by rng: both valid, rng_valid=0 for 10 cycles -> no ready, no add_en; on rng_valid=1, req0 is accepted.
- Backpressure: rsp0_ready held 0 for 20 cycles -> rsp0_valid and rsp_rd stable, req1 not accepted; after rsp0_ready=1, req1 is accepted the next cycle.
- Reset mid-RUN: assert g_resetn=0 at T+3 -> add_en=0 and all valids 0 immediately; after release, a new req0 completes normally. With SME_ARB_ZEROISE_EN, rsp_rd reads 0 one cycle after the handoff.
